// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// PROG_LOADER_CHECKSUM_EN adds the trailing checksum state.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        , ST_CHK
`endif
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch filter, centre sampling.
module uart_rx #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          rx_prev;
    logic [1:0]    st;
    logic [CW-1:0] baud;
    logic [2:0]    bit_cnt;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            st       <= RX_IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx_in};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            baud     <= baud + 1'b1;
            case (st)
                RX_IDLE: begin
                    baud <= '0;
                    if (rx_prev && !rx_s) st <= RX_START;
                end
                // a start bit that is high again at mid-bit was a glitch
                RX_START: if (baud == HALF) begin
                    baud    <= '0;
                    bit_cnt <= '0;
                    st      <= rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (baud == FULL) begin
                    baud    <= '0;
                    rx_data <= {rx_s, rx_data[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) st <= RX_STOP;
                end
                default: if (baud == FULL) begin
                    baud     <= '0;
                    rx_valid <= 1'b1;
                    rx_ferr  <= ~rx_s;
                    st       <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a UART frame and writes 32-bit words into instruction RAM.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLK_DIV = 868,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic              load_done,
    output logic              load_err
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam loader_state_t ST_FIN = ST_CHK;
`else
    localparam loader_state_t ST_FIN = ST_DONE;
`endif

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [15:0]   len_full;
    logic          len_too_big;
    logic          last_word;

    assign len_full    = {rx_data, len_lo};
    assign len_too_big = {1'b0, len_full} > (17'd1 << ADDR_W);
    // word index is one bit wider than the address so a full-RAM image compares cleanly
    assign last_word   = (word_idx + 1'b1) == word_cnt;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (state == ST_IDLE)
            sum <= '0;
        else if (rx_valid && state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA})
            sum <= sum + rx_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_rst_n <= 1'b0;
            loading   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            len_lo    <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
        end else begin
            ram_we    <= 1'b0;
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // the CPU stays held after a failed load until a new image arrives
                    cpu_rst_n <= ~load_err;
                    if (rx_valid && !rx_ferr && rx_data == SYNC_BYTE) begin
                        state     <= ST_LEN_LO;
                        loading   <= 1'b1;
                        cpu_rst_n <= 1'b0;
                        load_err  <= 1'b0;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                    end
                end
                ST_LEN_LO: if (rx_valid) begin
                    len_lo <= rx_data;
                    state  <= rx_ferr ? ST_ERR : ST_LEN_HI;
                end
                ST_LEN_HI: if (rx_valid) begin
                    word_cnt <= (ADDR_W+1)'(len_full);
                    if (rx_ferr || len_too_big) state <= ST_ERR;
                    else if (len_full == 16'd0) state <= ST_FIN;
                    else                        state <= ST_DATA;
                end
                ST_DATA: if (rx_valid) begin
                    if (rx_ferr) begin
                        state <= ST_ERR;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        word_buf <= {rx_data, word_buf[23:8]};
                        if (byte_idx == 2'd3) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= word_idx[ADDR_W-1:0];
                            ram_wdata <= {rx_data, word_buf};
                            word_idx  <= word_idx + 1'b1;
                            if (last_word) state <= ST_FIN;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK: if (rx_valid) begin
                    state <= (rx_ferr || rx_data != sum) ? ST_ERR : ST_DONE;
                end
`endif
                ST_DONE: begin
                    load_done <= 1'b1;
                    loading   <= 1'b0;
                    cpu_rst_n <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ERR: begin
                    load_err  <= 1'b1;
                    loading   <= 1'b0;
                    cpu_rst_n <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames vs a frame-level model.
module tb_prog_loader;

    localparam int CLK_DIV = 8;
    localparam int ADDR_W  = 12;

    typedef logic [ADDR_W+31:0] wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_in = 1'b1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              cpu_rst_n;
    logic              loading;
    logic              load_done;
    logic              load_err;

    prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_rst_n (cpu_rst_n),
        .loading   (loading),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observation (written only here)
    wr_t wr_q[$];
    int  done_cnt = 0;
    int  viol_cnt = 0;
    int  load_cyc = 0;

    always @(negedge clk) begin
        if (ram_we) wr_q.push_back({ram_addr, ram_wdata});
        if (load_done) done_cnt++;
        if (loading && cpu_rst_n) viol_cnt++;
        if (loading) load_cyc++;
    end

    // stimulus frame and model expectations
    logic [7:0] frm[$];
    wr_t        exp_q[$];
    int         exp_done;
    bit         exp_err;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = fr[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_in = 1'b1;
    endtask

    task automatic send_frame(input int ferr_idx);
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i], i != ferr_idx);
            if (i == ferr_idx) break;
        end
        repeat (3 * CLK_DIV) @(negedge clk);
    endtask

    // Frame-level reference: parse the byte list as the protocol defines it.
    task automatic model(input int ferr_idx);
        int n;
        int p;
        logic [7:0] s;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 1'b0;
        if (ferr_idx == 1 || ferr_idx == 2) begin exp_err = 1'b1; return; end
        n = int'(frm[1]) + 256 * int'(frm[2]);
        s = frm[1] + frm[2];
        if (n > (1 << ADDR_W)) begin exp_err = 1'b1; return; end
        for (int w = 0; w < n; w++) begin
            p = 3 + 4 * w;
            if (ferr_idx >= p && ferr_idx < p + 4) begin exp_err = 1'b1; return; end
            exp_q.push_back({ADDR_W'(w), frm[p+3], frm[p+2], frm[p+1], frm[p]});
            s = s + frm[p] + frm[p+1] + frm[p+2] + frm[p+3];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (ferr_idx == 3 + 4 * n || frm[3 + 4 * n] != s) begin exp_err = 1'b1; return; end
`endif
        exp_done = 1;
    endtask

    task automatic test_reset();
        int b, d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_we, ram_addr, ram_wdata, cpu_rst_n, loading, load_done, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got we=%b addr=%h wd=%h crst=%b ld=%b dn=%b er=%b want all 0",
                     ram_we, ram_addr, ram_wdata, cpu_rst_n, loading, load_done, load_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL reset_cpu_rel: got %b want 1", cpu_rst_n); end
        checks++;
        if ({ram_we, loading, load_done, load_err} !== 4'b0) begin
            errors++; $display("FAIL reset_rel_outs: got %b want 0000", {ram_we, loading, load_done, load_err});
        end
        b = wr_q.size(); d = done_cnt;
        frm = '{8'h5A, 8'h00};
        send_frame(-1);
        checks++;
        if ({loading, load_err, cpu_rst_n} !== 3'b001 || wr_q.size() != b || done_cnt != d) begin
            errors++;
            $display("FAIL idle_junk: got ld=%b er=%b crst=%b wr=%0d dn=%0d want 0 0 1 0 0",
                     loading, load_err, cpu_rst_n, wr_q.size() - b, done_cnt - d);
        end
    endtask

    task automatic test_basic();
        int b, d, v, l;
        wr_t ex[2];
        wr_t got;
        ex[0] = {12'h000, 32'h0000_0013};
        ex[1] = {12'h001, 32'h5634_12B7};
        b = wr_q.size(); d = done_cnt; v = viol_cnt; l = load_cyc;
        frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h34, 8'h56};
`ifdef PROG_LOADER_CHECKSUM_EN
        frm.push_back(8'h68);
`endif
        send_frame(-1);
        checks++;
        if (wr_q.size() - b != 2) begin errors++; $display("FAIL basic_nwr: got %0d want 2", wr_q.size() - b); end
        for (int i = 0; i < 2; i++) begin
            got = (b + i < wr_q.size()) ? wr_q[b + i] : 'x;
            checks++;
            if (got !== ex[i]) begin errors++; $display("FAIL basic_wr%0d: got %h want %h", i, got, ex[i]); end
        end
        checks++;
        if (done_cnt - d != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt - d); end
        checks++;
        if (viol_cnt != v || load_cyc == l) begin
            errors++; $display("FAIL basic_cpu_hold: got viol=%0d loadcyc=%0d want 0 and >0", viol_cnt - v, load_cyc - l);
        end
        checks++;
        if ({cpu_rst_n, loading, load_err} !== 3'b100) begin
            errors++; $display("FAIL basic_end: got %b want 100", {cpu_rst_n, loading, load_err});
        end
        checks++;
        if ({ram_addr, ram_wdata} !== ex[1]) begin
            errors++; $display("FAIL basic_hold: got %h want %h", {ram_addr, ram_wdata}, ex[1]);
        end
    endtask

    task automatic test_zero_len();
        int b, d;
        b = wr_q.size(); d = done_cnt;
        frm = '{8'hA5, 8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
        frm.push_back(8'h00);
`endif
        send_frame(-1);
        checks++;
        if (wr_q.size() != b || done_cnt - d != 1) begin
            errors++; $display("FAIL zero_len: got wr=%0d dn=%0d want 0 1", wr_q.size() - b, done_cnt - d);
        end
        checks++;
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_cpu: got %b want 1", cpu_rst_n); end
    endtask

    task automatic test_too_long();
        int b, d;
        wr_t got;
        b = wr_q.size(); d = done_cnt;
        frm = '{8'hA5, 8'h01, 8'h10};
        send_frame(-1);
        checks++;
        if ({load_err, cpu_rst_n, loading} !== 3'b100 || done_cnt != d || wr_q.size() != b) begin
            errors++;
            $display("FAIL too_long: got er=%b crst=%b ld=%b dn=%0d wr=%0d want 1 0 0 0 0",
                     load_err, cpu_rst_n, loading, done_cnt - d, wr_q.size() - b);
        end
        frm = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef PROG_LOADER_CHECKSUM_EN
        frm.push_back(8'h39);
`endif
        send_frame(-1);
        got = (b < wr_q.size()) ? wr_q[b] : 'x;
        checks++;
        if (got !== {12'h000, 32'hEFBE_ADDE}) begin errors++; $display("FAIL recover_wr: got %h want %h", got, {12'h000, 32'hEFBE_ADDE}); end
        checks++;
        if ({load_err, cpu_rst_n} !== 2'b01 || done_cnt - d != 1) begin
            errors++; $display("FAIL recover_state: got er=%b crst=%b dn=%0d want 0 1 1", load_err, cpu_rst_n, done_cnt - d);
        end
    endtask

    task automatic test_ferr();
        int b, d;
        b = wr_q.size(); d = done_cnt;
        frm = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(5);
        checks++;
        if ({load_err, cpu_rst_n, loading} !== 3'b100 || wr_q.size() != b || done_cnt != d) begin
            errors++;
            $display("FAIL ferr: got er=%b crst=%b ld=%b wr=%0d dn=%0d want 1 0 0 0 0",
                     load_err, cpu_rst_n, loading, wr_q.size() - b, done_cnt - d);
        end
    endtask

    task automatic test_reset_mid();
        int b, d;
        wr_t got;
        frm = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b1);
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (loading !== 1'b1) begin errors++; $display("FAIL mid_loading: got %b want 1", loading); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_we, ram_addr, ram_wdata, cpu_rst_n, loading, load_done, load_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outs: got we=%b addr=%h wd=%h crst=%b ld=%b dn=%b er=%b want all 0",
                     ram_we, ram_addr, ram_wdata, cpu_rst_n, loading, load_done, load_err);
        end
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        b = wr_q.size(); d = done_cnt;
        frm = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef PROG_LOADER_CHECKSUM_EN
        frm.push_back(8'h0B);
`endif
        send_frame(-1);
        got = (b < wr_q.size()) ? wr_q[b] : 'x;
        checks++;
        if (got !== {12'h000, 32'h0403_0201} || wr_q.size() - b != 1 || done_cnt - d != 1) begin
            errors++; $display("FAIL mid_restart: got %h n=%0d dn=%0d want %h 1 1", got, wr_q.size() - b, done_cnt - d, {12'h000, 32'h0403_0201});
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int d;
        d = done_cnt;
        frm = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        send_frame(-1);
        checks++;
        if (done_cnt - d != 1 || load_err !== 1'b0) begin
            errors++; $display("FAIL chk_good: got dn=%0d er=%b want 1 0", done_cnt - d, load_err);
        end
        d = done_cnt;
        frm[7] = 8'h0C;
        send_frame(-1);
        checks++;
        if (done_cnt != d || {load_err, cpu_rst_n} !== 2'b10) begin
            errors++; $display("FAIL chk_bad: got dn=%0d er=%b crst=%b want 0 1 0", done_cnt - d, load_err, cpu_rst_n);
        end
    endtask
`endif

    task automatic test_random();
        int n, b, d, fe, v;
        logic [7:0] s;
        wr_t got;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 5);
            frm = '{8'hA5, 8'(n), 8'h00};
            s = 8'(n);
            for (int k = 0; k < 4 * n; k++) begin
                frm.push_back(8'($urandom));
                s = s + frm[frm.size() - 1];
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if ($urandom_range(3) == 0) s = s + 8'd1;
            frm.push_back(s);
`endif
            fe = ($urandom_range(3) == 0) ? $urandom_range(3, 3 + 4 * n - 1) : -1;
            model(fe);
            b = wr_q.size(); d = done_cnt; v = viol_cnt;
            send_frame(fe);
            checks++;
            if (wr_q.size() - b != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_nwr: got %0d want %0d", t, wr_q.size() - b, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (b + i < wr_q.size()) ? wr_q[b + i] : 'x;
                checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL rand%0d_wr%0d: got %h want %h", t, i, got, exp_q[i]); end
            end
            checks++;
            if (done_cnt - d != exp_done || load_err !== exp_err || cpu_rst_n !== !exp_err || viol_cnt != v) begin
                errors++;
                $display("FAIL rand%0d_state: got dn=%0d er=%b crst=%b viol=%0d want %0d %b %b 0",
                         t, done_cnt - d, load_err, cpu_rst_n, viol_cnt - v, exp_done, exp_err, !exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_ferr();
        test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial boot loader that receives a program image over an 8N1 UART line and writes it word by word into the CPU's 4096×32 instruction RAM. It is the write side of the instruction memory that the CPU fetch stage reads. It holds the CPU in reset while an image is streaming in and releases it once the last word has been written.

## Interface
- `CLK_DIV`, default 868: clocks per UART bit (100 MHz / 115200); minimum 4.
- `ADDR_W`, default 12: instruction RAM word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1: system clock.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `rx_in`  in  1: UART receive line, idle high, asynchronous to `clk`.
- `ram_we`  out  1: instruction RAM write strobe, one cycle per word.
- `ram_addr`  out  ADDR_W: word address.
- `ram_wdata`  out  32: word data.
- `cpu_rst_n`  out  1: active-low reset to the CPU; low while loading or after an error.
- `loading`  out  1: high from sync byte accepted until DONE or ERR.
- `load_done`  out  1: one-cycle pulse when the image is complete.
- `load_err`  out  1: sticky; cleared by `rst_n` or by a new sync byte.

## Operation
- Frame format: `0xA5` sync byte, then a word count N (16 bit, low byte first), then N words of 4 bytes each, least significant byte first. An optional checksum byte follows (see Configuration).
- Receiver behaviour:
  - `rx_in` passes through a 2-FF synchronizer.
  - A falling edge starts a byte. The start bit is re-checked at CLK_DIV/2; if it is high, the edge is treated as a glitch and ignored.
  - Data bits are sampled every CLK_DIV cycles from the centre of the start bit, LSB first.
  - The stop bit is sampled once. If it is 0 the byte is flagged with a framing error.
- States:
  - IDLE: any byte other than a good `0xA5` is ignored. A good `0xA5` → LEN_LO, with `loading`=1 and `cpu_rst_n`=0.
  - LEN_LO → LEN_HI.
  - After LEN_HI:
    - N=0 → DONE.
    - N > 2^ADDR_W → ERR.
    - Otherwise → DATA.
  - DATA: a 2-bit byte index assembles each word. On the 4th byte, `ram_we` pulses with `ram_addr` set to the word index, starting at 0. After word N-1 → CHK if the macro is set, else DONE.
  - DONE: `load_done` pulses, `loading`=0, `cpu_rst_n`=1. The FSM then returns to IDLE.
  - ERR: `load_err`=1, `loading`=0, `cpu_rst_n` stays 0. The FSM then returns to IDLE, where only a new `0xA5` restarts loading.
  - A framing error in any state except IDLE → ERR.
- Word index is ADDR_W+1 bits wide, so N = 2^ADDR_W does not wrap before the final comparison.
- A sync byte received in IDLE after DONE or ERR starts a new load and clears `load_err`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `cpu_rst_n`=0, `loading`=0, `load_done`=0, `load_err`=0.
  - `cpu_rst_n` rises on the first clock edge after `rst_n` deasserts (IDLE drives 1).
- Byte valid is asserted internally one cycle after the stop-bit sample.
- `ram_we`, `ram_addr` and `ram_wdata` are registered and become valid the cycle after byte valid. `ram_addr` and `ram_wdata` hold their values until the next write.
- `load_done` and the `cpu_rst_n` rise occur in the cycle after the final `ram_we` (no checksum), or after the checksum byte is accepted.
- Asserting `rst_n` mid-frame discards the partial word. RAM contents already written are not rolled back.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - A checksum byte follows the last word. It equals the 8-bit sum modulo 256 of every byte after the sync byte (the length bytes and all data bytes).
  - Match → DONE. Mismatch → ERR.
  - For N=0 the checksum byte is still expected.
- Macro undefined: no CHK state and no sum register. The loader goes straight to DONE after the last word, or after the length bytes when N=0.

## Structure
- Package `prog_loader_pkg`:
  - State enum `loader_state_t`.
  - `SYNC_BYTE = 8'hA5`.
- Sub-module `uart_rx`:
  - Parameter: `CLK_DIV`.
  - Ports: `clk`, `rst_n`, `rx_in`, `rx_data[7:0]`, `rx_valid`, `rx_ferr`.
  - Contains the synchronizer, bit counter and baud counter.
- `prog_loader` holds only the frame FSM, word assembly, counters and outputs.

## Test plan
All cases use `CLK_DIV`=8.
- Reset release → `cpu_rst_n` goes 1 after one cycle and all other outputs stay 0. Sending `0x5A` then `0x00` → no state change.
- Frame `A5 02 00 13 00 00 00 B7 12 34 56` → two `ram_we` pulses: addr 0 with 0x00000013, then addr 1 with 0x563412B7. `load_done` pulses once. `cpu_rst_n` is 0 from the sync byte until done.
- Frame `A5 00 00` → `load_done` pulses and there is no `ram_we`. With the macro set, the bench adds checksum `00`.
- Length `01 10` (4097) → `load_err`=1 and `cpu_rst_n` stays 0. A following valid frame clears `load_err` and completes.
- Stop bit forced to 0 on the 3rd data byte → ERR and no `ram_we` for that word. `rst_n` pulsed mid-byte → all outputs return to reset values.
- Macro set, frame `A5 01 00 01 02 03 04`:
  - Checksum `0B` → DONE.
  - Checksum `0C` → `load_err`=1 and `cpu_rst_n`=0.
